alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer and two-port arbiter for the shared 32-bit combinational ALU. Two requesters, typically the execute stage and a secondary client such as the crypto/DMA path, submit an opcode and operands with a valid/ready handshake. The block grants the ALU round-robin, holds the operands stable for the required number of cycles (one cycle, or `MULDIV_LAT` cycles for MUL/DIV), registers the result and returns it to the winning port with a one-cycle response pulse.

## Interface
- `MULDIV_LAT`, default 4: execute cycles for `MUL`/`DIV`; legal range 1–15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: port 0 request valid.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_op` in 5: port 0 ALU control code (`parameter.v` encodings: `ADD`, `SUB`, `MUL`, `DIV`, `INC`, `DEC`, `AND`, `OR`, `XOR`, `ENCRY`, `DECRY`).
- `req0_a`, `req0_b` in 32 each: port 0 operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: port 1 equivalents of the port 0 signals.
- `rsp0_valid` out 1: one-cycle result pulse for port 0.
- `rsp1_valid` out 1: one-cycle result pulse for port 1.
- `rsp_data` out 32: result; valid while either `rsp*_valid` is high.
- `rsp_err` out 1: error qualifier; valid with `rsp*_valid`.
- `alu_in1`, `alu_in2` out 32: ALU operand drive.
- `alu_ctrl` out 5: ALU opcode drive.
- `alu_out` in 32: ALU result.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE:**
  - Grant is combinational: `reqN_ready = (state==IDLE) && reqN_valid && winner==N`.
  - A handshake is `valid && ready`.
  - On a handshake: latch op, a, b and the port ID; load the execute counter with 1, or with `MULDIV_LAT` for `MUL`/`DIV`; go to EXEC.
- **Arbitration:**
  - With one valid requester, that requester wins.
  - With both valid, the port not granted last wins.
  - After reset, port 0 wins a tie.
  - The last-grant pointer updates only on a handshake.
- **EXEC:**
  - `alu_in1`/`alu_in2`/`alu_ctrl` are the latched registers, stable for the whole EXEC.
  - The counter decrements each cycle.
  - On the cycle the counter equals 1: capture `alu_out` into `rsp_data`, compute `rsp_err`, go to DONE.
- **DONE:**
  - Assert `rsp<id>_valid` for exactly one cycle.
  - Next state is IDLE unconditionally.
  - No acceptance in DONE.
- **Response rules:**
  - No backpressure on responses; a requester must sample the pulse.
  - `rsp_data`/`rsp_err` hold their value until the next capture.
- **Opcodes:**
  - Unknown opcodes are forwarded unchanged and take one cycle.
  - The ALU returns 0 for them, and `rsp_err` is 0.
- **ALU drive:** `alu_*` outputs keep the last latched values when idle.
- **Requester obligations:** a requester holds `valid`, op and operands stable until `ready`. Dropping `valid` before grant is legal and has no effect.
- **Reset:**
  - All outputs go to 0, state to IDLE, pointer to "port 1 last".
  - Reset mid-EXEC or in DONE aborts the operation and produces no response pulse.

## Timing
- Handshake sampled at edge T; EXEC occupies cycles T+1 … T+L, with L = 1 or `MULDIV_LAT`.
- `rsp_valid` is high in cycle T+L+1.
- Earliest next handshake is at edge T+L+2.
- Single-cycle op throughput: one per 3 cycles. `MUL`/`DIV`: one per `MULDIV_LAT`+2 cycles.
- `reqN_ready` is combinational from `reqN_valid` and state; all other outputs are registered.

## Configuration
- Macro `ALU_DIV0_CHK_EN`.
- **Defined:** for `DIV` with latched b == 0, the captured `rsp_data` is forced to 0 and `rsp_err` = 1. For all other operations `rsp_err` = 0.
- **Undefined:** `alu_out` is captured unmodified, and `rsp_err` is tied to 0.
- Timing is identical either way.

## Test plan
- **Single request, 1-cycle op:** reset, then port 0 `ADD` a=5, b=7 → `req0_ready` at T; `rsp0_valid` at T+2 with `rsp_data`=12; `rsp1_valid` stays 0; `busy` high T+1..T+2.
- **Both ports valid every cycle:**
  - Stimulus: port 0 `SUB` 10−3, port 1 `XOR` 0xF0F0^0x0FF0, each held valid continuously.
  - Required: grants alternate 0,1,0,1; responses are 7 then 0xFF00, repeating; no handshake during EXEC or DONE.
- **Multi-cycle op:** port 1 `MUL` 6×7 with `MULDIV_LAT`=4 → `alu_*` stable T+1..T+4; `rsp1_valid` only at T+5 with 42; port 0 request made at T+2 is granted at T+6.
- **Divide by zero:** `DIV` 100/0 → with `ALU_DIV0_CHK_EN`, `rsp_data`=0 and `rsp_err`=1; `DIV` 100/4 → `rsp_data`=25, `rsp_err`=0.
- **Reset mid-operation:** assert `rst` in the second EXEC cycle of a `DIV` → outputs 0 immediately, no `rsp*_valid` ever. After release, a tie between both ports is granted to port 0 first.
- **Encrypt round trip:** `ENCRY` on 0x12345678, then `DECRY` on that result → 0x12345678.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two ALU clients and the
// alu_arbiter. The master modport is the requester side, slave is the arbiter.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer in front of the shared 32-bit
// combinational ALU. Grants one of two requesters, holds the operands on the
// ALU for 1 cycle (MULDIV_LAT cycles for MUL/DIV), registers the result and
// returns it with a one-cycle pulse on the winning port.
// Optional feature: define ALU_DIV0_CHK_EN to force a zero result and flag
// rsp_err for DIV with a zero divisor.
module alu_arbiter #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  output logic        busy
);

  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [3:0] LAT_MD = 4'(MULDIV_LAT);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        port_id;
  logic [3:0]  exec_cnt;
  logic        winner;
  logic        hs0;
  logic        hs1;
  logic [4:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] capture_data;
  logic        capture_err;

  // Pick the winning port: a lone requester wins, a tie goes to the port not granted last
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      winner = ~last_grant;
    end else begin
      winner = bus.req1_valid;
    end
  end

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !winner;
  assign bus.req1_ready = (state == IDLE) && bus.req1_valid && winner;
  assign hs0 = bus.req0_valid && bus.req0_ready;
  assign hs1 = bus.req1_valid && bus.req1_ready;

  assign sel_op = hs1 ? bus.req1_op : bus.req0_op;
  assign sel_a  = hs1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = hs1 ? bus.req1_b  : bus.req0_b;

  // Qualify the ALU result before it is captured (divide-by-zero screening when enabled)
  always_comb begin
    capture_data = alu_out;
    capture_err  = 1'b0;
`ifdef ALU_DIV0_CHK_EN
    if ((alu_ctrl == OP_DIV) && (alu_in2 == 32'd0)) begin
      capture_data = 32'd0;
      capture_err  = 1'b1;
    end
`else
`endif
  end

  // Sequencer FSM: accept in IDLE, hold operands through EXEC, pulse the response in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      port_id        <= 1'b0;
      exec_cnt       <= 4'd0;
      alu_in1        <= 32'd0;
      alu_in2        <= 32'd0;
      alu_ctrl       <= 5'd0;
      busy           <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_data   <= 32'd0;
      bus.rsp_err    <= 1'b0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hs0 || hs1) begin
            alu_ctrl   <= sel_op;
            alu_in1    <= sel_a;
            alu_in2    <= sel_b;
            port_id    <= hs1;
            last_grant <= hs1;
            exec_cnt   <= ((sel_op == OP_MUL) || (sel_op == OP_DIV)) ? LAT_MD : 4'd1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          exec_cnt <= exec_cnt - 4'd1;
          if (exec_cnt == 4'd1) begin
            bus.rsp_data   <= capture_data;
            bus.rsp_err    <= capture_err;
            bus.rsp0_valid <= ~port_id;
            bus.rsp1_valid <= port_id;
            state          <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized bench for alu_arbiter. Plays the
// external ALU, both requesters, and predicts grants/results from a
// transaction-level model of the arbitration and opcode rules.
module tb_alu_arbiter;

  localparam int LAT = 4;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_MUL   = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_INC   = 5'd4;
  localparam logic [4:0] OP_DEC   = 5'd5;
  localparam logic [4:0] OP_AND   = 5'd6;
  localparam logic [4:0] OP_OR    = 5'd7;
  localparam logic [4:0] OP_XOR   = 5'd8;
  localparam logic [4:0] OP_ENCRY = 5'd9;
  localparam logic [4:0] OP_DECRY = 5'd10;
  localparam logic [31:0] KEY     = 32'hA5C3_5A3C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  bit model_last;

  alu_arbiter_if bus ();

  alu_arbiter #(.MULDIV_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour, also used to drive the DUT's alu_out
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_MUL:   return a * b;
      OP_DIV:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_INC:   return a + 32'd1;
      OP_DEC:   return a - 32'd1;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_ENCRY: return {a[24:0], a[31:25]} ^ KEY;
      OP_DECRY: begin
        t = a ^ KEY;
        return {t[6:0], t[31:7]};
      end
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_ctrl, alu_in1, alu_in2);

  // Expected {rsp_err, rsp_data} for a served request
  function automatic logic [32:0] expect_rsp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_DIV0_CHK_EN
    if ((op == OP_DIV) && (b == 32'd0)) return {1'b1, 32'd0};
`else
`endif
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  function automatic int latency_of(input logic [4:0] op);
    return ((op == OP_MUL) || (op == OP_DIV)) ? LAT : 1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int port, input bit valid, input logic [4:0] op,
                                input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      bus.req0_valid = valid; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = valid; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_rsp0"}, 32'(bus.rsp0_valid), 32'd0);
    check_output({tag, "_rsp1"}, 32'(bus.rsp1_valid), 32'd0);
    check_output({tag, "_data"}, bus.rsp_data, 32'd0);
    check_output({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    check_output({tag, "_in1"}, alu_in1, 32'd0);
    check_output({tag, "_in2"}, alu_in2, 32'd0);
    check_output({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    apply_stimulus(0, 1'b0, 5'd0, 32'd0, 32'd0);
    apply_stimulus(1, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  // Wait for a grant, then follow the transaction through EXEC and DONE.
  // Called at (or just after) a falling edge; returns one cycle after DONE.
  task automatic serve(input bit keep, input int exp_wait, input int raise0_at);
    int waited;
    int port;
    int lat;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
    waited = 0;
    #1;
    while (!(bus.req0_ready || bus.req1_ready) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    vectors++;
    assert (bus.req0_ready || bus.req1_ready) else begin
      miscompares++;
      $error("[TB] FAIL grant_timeout observed=no_ready expected=ready within 20 cycles");
      return;
    end
    if (exp_wait >= 0) check_output("grant_wait", 32'(waited), 32'(exp_wait));
    if (bus.req0_valid && bus.req1_valid) port = model_last ? 0 : 1;
    else port = bus.req1_valid ? 1 : 0;
    check_output("ready0", 32'(bus.req0_ready), 32'(port == 0));
    check_output("ready1", 32'(bus.req1_ready), 32'(port == 1));
    op = (port == 1) ? bus.req1_op : bus.req0_op;
    a  = (port == 1) ? bus.req1_a  : bus.req0_a;
    b  = (port == 1) ? bus.req1_b  : bus.req0_b;
    model_last = (port == 1);
    lat = latency_of(op);
    exp = expect_rsp(op, a, b);
    @(posedge clk);
    #1;
    if (!keep) apply_stimulus(port, 1'b0, op, a, b);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      #1;
      if (raise0_at == k) bus.req0_valid = 1'b1;
      check_output("busy", 32'(busy), 32'd1);
      check_output("alu_ctrl", 32'(alu_ctrl), 32'(op));
      check_output("alu_in1", alu_in1, a);
      check_output("alu_in2", alu_in2, b);
      check_output("no_accept0", 32'(bus.req0_ready), 32'd0);
      check_output("no_accept1", 32'(bus.req1_ready), 32'd0);
      if (k <= lat) begin
        check_output("early_rsp0", 32'(bus.rsp0_valid), 32'd0);
        check_output("early_rsp1", 32'(bus.rsp1_valid), 32'd0);
      end else begin
        check_output("rsp0_valid", 32'(bus.rsp0_valid), 32'(port == 0));
        check_output("rsp1_valid", 32'(bus.rsp1_valid), 32'(port == 1));
        check_output("rsp_data", bus.rsp_data, exp[31:0]);
        check_output("rsp_err", 32'(bus.rsp_err), 32'(exp[32]));
      end
    end
    @(negedge clk);
    #1;
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("pulse_end", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
  endtask

  function automatic logic [4:0] rand_op();
    return 5'($urandom_range(0, 12));
  endfunction

  function automatic logic [31:0] rand_b();
    return ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
  endfunction

  // Directed scenarios followed by a randomized two-port run
  initial begin
    logic [31:0] enc;
    rst = 1'b1;
    model_last = 1'b1;
    apply_reset();

    $display("[TB] single ADD on port 0");
    apply_stimulus(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    serve(1'b0, 0, 0);
    check_output("add_result", bus.rsp_data, 32'd12);

    $display("[TB] both ports valid continuously");
    apply_reset();
    apply_stimulus(0, 1'b1, OP_SUB, 32'd10, 32'd3);
    apply_stimulus(1, 1'b1, OP_XOR, 32'hF0F0, 32'h0FF0);
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, 0, 0);
      check_output("alt_result", bus.rsp_data, (i % 2 == 0) ? 32'd7 : 32'hFF00);
    end
    apply_stimulus(0, 1'b0, OP_SUB, 32'd10, 32'd3);
    apply_stimulus(1, 1'b0, OP_XOR, 32'hF0F0, 32'h0FF0);

    $display("[TB] multi-cycle MUL with late port 0 request");
    apply_stimulus(0, 1'b0, OP_INC, 32'd41, 32'd0);
    apply_stimulus(1, 1'b1, OP_MUL, 32'd6, 32'd7);
    serve(1'b0, 0, 2);
    check_output("mul_result", bus.rsp_data, 32'd42);
    serve(1'b0, 0, 0);
    check_output("inc_result", bus.rsp_data, 32'd42);

    $display("[TB] divide by zero and normal divide");
    apply_stimulus(0, 1'b1, OP_DIV, 32'd100, 32'd0);
    serve(1'b0, 0, 0);
`ifdef ALU_DIV0_CHK_EN
    check_output("div0_data", bus.rsp_data, 32'd0);
    check_output("div0_err", 32'(bus.rsp_err), 32'd1);
`else
    check_output("div0_data", bus.rsp_data, 32'hFFFF_FFFF);
    check_output("div0_err", 32'(bus.rsp_err), 32'd0);
`endif
    apply_stimulus(0, 1'b1, OP_DIV, 32'd100, 32'd4);
    serve(1'b0, 0, 0);
    check_output("div_data", bus.rsp_data, 32'd25);
    check_output("div_err", 32'(bus.rsp_err), 32'd0);

    $display("[TB] encrypt round trip");
    apply_stimulus(1, 1'b1, OP_ENCRY, 32'h1234_5678, 32'd0);
    serve(1'b0, 0, 0);
    enc = alu_fn(OP_ENCRY, 32'h1234_5678, 32'd0);
    apply_stimulus(1, 1'b1, OP_DECRY, enc, 32'd0);
    serve(1'b0, 0, 0);
    check_output("round_trip", bus.rsp_data, 32'h1234_5678);

    $display("[TB] reset during EXEC");
    apply_stimulus(0, 1'b1, OP_DIV, 32'd100, 32'd4);
    #1;
    check_output("mid_ready", 32'(bus.req0_ready), 32'd1);
    @(posedge clk);
    #1;
    apply_stimulus(0, 1'b0, OP_DIV, 32'd100, 32'd4);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check_output("aborted_rsp", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
    end
    apply_stimulus(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    apply_stimulus(1, 1'b1, OP_OR, 32'h10, 32'h01);
    #1;
    check_output("tie_after_reset", 32'(bus.req0_ready), 32'd1);
    serve(1'b0, 0, 0);
    serve(1'b0, 0, 0);
    check_output("loser_result", bus.rsp_data, 32'h11);

    $display("[TB] randomized two-port traffic");
    for (int i = 0; i < 24; i++) begin
      if (!bus.req0_valid && ($urandom_range(0, 1) == 1))
        apply_stimulus(0, 1'b1, rand_op(), $urandom(), rand_b());
      if (!bus.req1_valid && ($urandom_range(0, 1) == 1))
        apply_stimulus(1, 1'b1, rand_op(), $urandom(), rand_b());
      if (!bus.req0_valid && !bus.req1_valid)
        apply_stimulus(int'($urandom_range(0, 1)), 1'b1, rand_op(), $urandom(), rand_b());
      serve(1'b0, 0, 0);
    end
    apply_stimulus(0, 1'b0, 5'd0, 32'd0, 32'd0);
    apply_stimulus(1, 1'b0, 5'd0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
